// File: rtl/mcs4_ram_array.sv
// Bank of 4002-class RAM chips behind one shared 4004 I/O command interface,
// with a post-reset clear sweep, registered read data and a read-valid strobe.
module mcs4_ram_array #(
    parameter int unsigned NCHIPS = 4,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned NCHARS = 16,
    localparam int unsigned CW    = (NCHIPS > 1) ? $clog2(NCHIPS) : 1,
    localparam int unsigned RW    = (NREGS  > 1) ? $clog2(NREGS)  : 1,
    localparam int unsigned KW    = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CW-1:0]         chip,
    input  logic [RW-1:0]         reg_sel,
    input  logic [KW-1:0]         char_sel,
    input  logic [3:0]            din,
    input  logic                  cs,
    input  logic [3:0]            opa,
    input  logic                  we,
    output logic [3:0]            dout,
    output logic                  rd_valid,
    output logic [4*NCHIPS-1:0]   port,
    output logic                  busy
);

    localparam int unsigned TOTAL = NCHIPS * NREGS * NCHARS;
    localparam int unsigned AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [3:0]            dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [4*NCHIPS-1:0]   port_q, port_d;
    logic                  busy_q, busy_d;

    logic [3:0]            mem_q  [NCHIPS][NREGS][NCHARS];
    logic [3:0]            stat_q [NCHIPS][NREGS][4];

    // Shared write port: the clear sweep and CPU writes never coincide.
    logic                  w_en_c;
    logic [CW-1:0]         w_chip_c;
    logic [RW-1:0]         w_reg_c;
    logic [KW-1:0]         w_char_c;
    logic [3:0]            w_data_c;
    logic [3:0]            s_mask_c;

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            dout_q     <= 4'h0;
            rd_valid_q <= 1'b0;
            port_q     <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            port_q     <= port_d;
            busy_q     <= busy_d;
        end
    end

    // Next state, command decode and write-port steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        port_d     = port_q;
        busy_d     = busy_q;
        w_en_c     = 1'b0;
        w_chip_c   = chip;
        w_reg_c    = reg_sel;
        w_char_c   = char_sel;
        w_data_c   = din;
        s_mask_c   = 4'h0;

        case (state_q)
            CLEAR: begin
                w_en_c   = 1'b1;
                s_mask_c = 4'hF;
                w_data_c = 4'h0;
                w_chip_c = CW'(32'(cnt_q) / (NREGS * NCHARS));
                w_reg_c  = RW'((32'(cnt_q) / NCHARS) % NREGS);
                w_char_c = KW'(32'(cnt_q) % NCHARS);
                if (cnt_q == AW'(TOTAL - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            IDLE: begin
                if (cs) begin
                    case (opa)
                        4'h0: w_en_c = we;
                        4'h1: begin
                            if (we) begin
                                for (int n = 0; n < NCHIPS; n++) begin
                                    if (chip == CW'(n)) port_d[4*n +: 4] = din;
                                end
                            end
                        end
                        4'h4, 4'h5, 4'h6, 4'h7: begin
                            if (we) s_mask_c[opa[1:0]] = 1'b1;
                        end
                        4'h8, 4'h9, 4'hB: begin
                            dout_d     = mem_q[chip][reg_sel][char_sel];
                            rd_valid_d = 1'b1;
                        end
                        4'hC, 4'hD, 4'hE, 4'hF: begin
                            dout_d     = stat_q[chip][reg_sel][opa[1:0]];
                            rd_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage arrays carry no reset; the clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_en_c) mem_q[w_chip_c][w_reg_c][w_char_c] <= w_data_c;
            for (int j = 0; j < 4; j++) begin
                if (s_mask_c[j]) stat_q[w_chip_c][w_reg_c][2'(j)] <= w_data_c;
            end
        end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign port     = port_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mcs4_ram_array.sv
// Scoreboard bench for mcs4_ram_array: reads push expected data, a forked
// monitor pops and compares on every rd_valid pulse.
module tb_mcs4_ram_array;

    logic        clk;
    logic        reset_n;
    logic [1:0]  chip;
    logic [1:0]  reg_sel;
    logic [3:0]  char_sel;
    logic [3:0]  din;
    logic        cs;
    logic [3:0]  opa;
    logic        we;
    logic [3:0]  dout;
    logic        rd_valid;
    logic [15:0] port;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  exp_q[$];
    int          cyc;

    mcs4_ram_array dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .chip     (chip),
        .reg_sel  (reg_sel),
        .char_sel (char_sel),
        .din      (din),
        .cs       (cs),
        .opa      (opa),
        .we       (we),
        .dout     (dout),
        .rd_valid (rd_valid),
        .port     (port),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached without summary");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Pops one expectation per rd_valid pulse; an unexpected pulse is a failure.
    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid !== 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_valid_unexpected got dout=%0h want no pulse", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        bad++;
                        $display("FAIL read_data got=%0h want=%0h", dout, e);
                    end
                end
            end
        end
    endtask

    // Issues one command for exactly one cycle; cs stays high for a following cmd.
    task automatic cmd(input int c, input int r, input int k, input logic [3:0] op,
                       input logic [3:0] d, input logic w, input bit rd, input logic [3:0] ev);
        chip     = 2'(c);
        reg_sel  = 2'(r);
        char_sel = 4'(k);
        opa      = op;
        din      = d;
        we       = w;
        cs       = 1'b1;
        if (rd) exp_q.push_back(ev);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cs = 1'b0;
        we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Releases reset and counts cycles until busy drops (or abort_at is reached).
    task automatic sweep(input int abort_at, input bit inject, output int cycles);
        int k;
        k = 0;
        reset_n = 1'b1;
        while (busy === 1'b1 && k < 400) begin
            if (abort_at >= 0 && k == abort_at) break;
            cs = 1'b0;
            if (inject && k == 254) begin
                chip = 2'd2; reg_sel = 2'd1; char_sel = 4'd5;
                opa = 4'h0; din = 4'hA; we = 1'b1; cs = 1'b1;
            end
            if (inject && k == 255) begin
                chip = 2'd2; reg_sel = 2'd1; char_sel = 4'd5;
                opa = 4'h9; we = 1'b0; cs = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        cs = 1'b0;
        we = 1'b0;
        cycles = k;
    endtask

    initial begin
        reset_n = 1'b0;
        cs = 1'b0; we = 1'b0; opa = 4'h0; din = 4'h0;
        chip = 2'd0; reg_sel = 2'd0; char_sel = 4'd0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_port", 32'(port), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);

        sweep(-1, 1'b1, cyc);
        check("clear_cycles", 32'(cyc), 32'd256);
        check("idle_busy", 32'(busy), 32'h0);

        // Memory and status all zero, busy-time write ignored
        cmd(2, 1, 5,  4'h9, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(0, 0, 0,  4'h9, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(3, 3, 15, 4'h9, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0,  4'hC, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0,  4'hD, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0,  4'hE, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0,  4'hF, 4'h0, 1'b0, 1'b1, 4'h0);

        // Write then read back-to-back
        cmd(3, 3, 15, 4'h0, 4'h7, 1'b1, 1'b0, 4'h0);
        cmd(3, 3, 15, 4'h9, 4'h0, 1'b0, 1'b1, 4'h7);
        cmd(0, 0, 0,  4'h9, 4'h0, 1'b0, 1'b1, 4'h0);
        idle(1);
        check("rd_valid_one_cycle", 32'(rd_valid), 32'h0);

        // Status characters
        cmd(1, 2, 0, 4'h6, 4'h5, 1'b1, 1'b0, 4'h0);
        cmd(1, 2, 0, 4'hE, 4'h0, 1'b0, 1'b1, 4'h5);
        cmd(1, 2, 0, 4'hD, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 3, 0, 4'hE, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0, 4'h6, 4'h9, 1'b0, 1'b0, 4'h0);
        cmd(1, 2, 0, 4'hE, 4'h0, 1'b0, 1'b1, 4'h5);
        cmd(1, 2, 0, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0);

        // WRM with we=0, other read opcodes, ROM-side opcodes ignored
        cmd(3, 3, 15, 4'h0, 4'h3, 1'b0, 1'b0, 4'h0);
        cmd(3, 3, 15, 4'h8, 4'h0, 1'b0, 1'b1, 4'h7);
        cmd(3, 3, 15, 4'hB, 4'h0, 1'b0, 1'b1, 4'h7);
        cmd(3, 3, 15, 4'hA, 4'hF, 1'b1, 1'b0, 4'h0);
        cmd(3, 3, 15, 4'h2, 4'hF, 1'b1, 1'b0, 4'h0);
        cmd(3, 3, 15, 4'h3, 4'hF, 1'b1, 1'b0, 4'h0);
        idle(2);
        check("dout_held", 32'(dout), 32'h7);
        cmd(3, 3, 15, 4'h9, 4'h0, 1'b0, 1'b1, 4'h7);

        // Output ports
        cmd(2, 0, 0, 4'h1, 4'hC, 1'b1, 1'b0, 4'h0);
        idle(1);
        check("port_wmp_chip2", 32'(port), 32'h0C00);
        cmd(2, 0, 0, 4'h1, 4'h3, 1'b0, 1'b0, 4'h0);
        idle(1);
        check("port_wmp_we0", 32'(port), 32'h0C00);
        cmd(0, 0, 0, 4'h1, 4'h5, 1'b1, 1'b0, 4'h0);
        idle(1);
        check("port_wmp_chip0", 32'(port), 32'h0C05);

        // Reset mid-clear restarts the sweep; ports only cleared by reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        sweep(100, 1'b0, cyc);
        check("midclear_busy_before", 32'(busy), 32'h1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midclear_port", 32'(port), 32'h0);
        check("midclear_busy", 32'(busy), 32'h1);
        check("midclear_dout", 32'(dout), 32'h0);
        sweep(-1, 1'b0, cyc);
        check("restart_clear_cycles", 32'(cyc), 32'd256);
        check("restart_port", 32'(port), 32'h0);
        cmd(3, 3, 15, 4'h9, 4'h0, 1'b0, 1'b1, 4'h0);
        cmd(1, 2, 0,  4'hE, 4'h0, 1'b0, 1'b1, 4'h0);
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
